// File: rtl/spipkt_read_arbiter.sv
// spipkt_read_arbiter: round-robin arbiter that lets four j4a threads share
// the single read port of the SPI packet receiver. It runs one read at a time:
// IDLE -> ISSUE (address strobe) -> WAIT (RD_LAT cycles) -> RESP (one-hot
// response pulse), and chains straight into the next ISSUE when more requests
// are pending.
//
// Optional feature macro: SPIPKT_ARB_FRESH_EN
//   defined   -> per-requester "fresh" flags set on every receiver page change
//   undefined -> fresh is tied to 0, fresh_clr is ignored
module spipkt_read_arbiter #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned NREQ   = 4
) (
  input  logic                clk,
  input  logic                resetq,
  input  logic [NREQ-1:0]     req,
  input  logic [6*NREQ-1:0]   req_addr,
  output logic [NREQ-1:0]     gnt,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [15:0]         rsp_data,
  output logic [1:0]          rsp_page,
  output logic                mem_setaddr,
  output logic [5:0]          mem_paddr,
  input  logic [15:0]         mem_pktwrd,
  input  logic [1:0]          mem_page,
  output logic [NREQ-1:0]     fresh,
  input  logic [NREQ-1:0]     fresh_clr
);

  localparam int unsigned IDXW  = $clog2(NREQ);
  localparam int unsigned CNTW  = 3;
  localparam int unsigned ADDRW = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDXW-1:0]   win_q;
  logic [IDXW-1:0]   last_served_q;
  logic [CNTW-1:0]   cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [15:0]       rsp_data_q;
  logic [1:0]        rsp_page_q;
  logic              mem_setaddr_q;
  logic [ADDRW-1:0]  mem_paddr_q;

  logic [IDXW-1:0]   win_c;
  logic [IDXW-1:0]   idx_c;
  logic              any_req_c;
  logic [ADDRW-1:0]  win_addr_c;

  // Round-robin pick: scan from last_served+1 upward; the nearest requester wins.
  always_comb begin
    win_c     = last_served_q;
    idx_c     = last_served_q;
    any_req_c = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_c = IDXW'(last_served_q + IDXW'(k));
      if (req[idx_c]) begin
        win_c     = idx_c;
        any_req_c = 1'b1;
      end
    end
    win_addr_c = req_addr[ADDRW*win_c +: ADDRW];
  end

  // Read sequencer: state, grant/strobe/response outputs, latency counter.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q       <= IDLE;
      win_q         <= '0;
      last_served_q <= IDXW'(NREQ - 1);
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      rsp_page_q    <= '0;
      mem_setaddr_q <= 1'b0;
      mem_paddr_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req_c) begin
            win_q         <= win_c;
            gnt_q         <= NREQ'(1) << win_c;
            mem_setaddr_q <= 1'b1;
            mem_paddr_q   <= win_addr_c;
            state_q       <= ISSUE;
          end
        end
        ISSUE: begin
          gnt_q         <= '0;
          mem_setaddr_q <= 1'b0;
          last_served_q <= win_q;
          cnt_q         <= CNTW'(RD_LAT - 1);
          state_q       <= WAIT;
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= mem_pktwrd;
            rsp_page_q  <= mem_page;
            rsp_valid_q <= NREQ'(1) << win_q;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CNTW'(1);
          end
        end
        RESP: begin
          rsp_valid_q <= '0;
          if (any_req_c) begin
            win_q         <= win_c;
            gnt_q         <= NREQ'(1) << win_c;
            mem_setaddr_q <= 1'b1;
            mem_paddr_q   <= win_addr_c;
            state_q       <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_page    = rsp_page_q;
  assign mem_setaddr = mem_setaddr_q;
  assign mem_paddr   = mem_paddr_q;

`ifdef SPIPKT_ARB_FRESH_EN
  logic [1:0]      prev_page_q;
  logic [NREQ-1:0] fresh_q;
  logic            page_chg_c;

  assign page_chg_c = (mem_page != prev_page_q);

  // Previous page tracks mem_page even in reset so release never looks like a change.
  always_ff @(posedge clk) begin
    prev_page_q <= mem_page;
  end

  // Fresh flags: a page change sets all of them; a simultaneous clear loses.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      fresh_q <= '0;
    end else begin
      fresh_q <= (fresh_q & ~fresh_clr) | {NREQ{page_chg_c}};
    end
  end

  assign fresh = fresh_q;
`else
  logic unused_fresh_clr;

  assign unused_fresh_clr = ^fresh_clr;
  assign fresh            = '0;
`endif

endmodule

// File: tb/tb_spipkt_read_arbiter.sv
// Directed bench for spipkt_read_arbiter (RD_LAT=2, NREQ=4).
module tb_spipkt_read_arbiter;

  logic        clk;
  logic        resetq;
  logic [3:0]  req;
  logic [23:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_page;
  logic        mem_setaddr;
  logic [5:0]  mem_paddr;
  logic [15:0] mem_pktwrd;
  logic [1:0]  mem_page;
  logic [3:0]  fresh;
  logic [3:0]  fresh_clr;

  logic        use_addr;
  logic [15:0] fixed_word;

  int n_checks;
  int n_pass;

  spipkt_read_arbiter #(.RD_LAT(2), .NREQ(4)) dut (
    .clk         (clk),
    .resetq      (resetq),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_page    (rsp_page),
    .mem_setaddr (mem_setaddr),
    .mem_paddr   (mem_paddr),
    .mem_pktwrd  (mem_pktwrd),
    .mem_page    (mem_page),
    .fresh       (fresh),
    .fresh_clr   (fresh_clr)
  );

  // Receiver model: either a fixed word or a word derived from the latched address.
  assign mem_pktwrd = use_addr ? (16'hB000 + {10'd0, mem_paddr}) : fixed_word;

  always #5 clk = ~clk;

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetq = 1'b0;
    step();
    step();
    resetq = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b0000; fresh_clr = 4'b0000; mem_page = 2'd1;
    do_reset();
    n_checks++; if (gnt !== 4'b0000) $display("FAIL reset_gnt: got %b expected 0000", gnt); else n_pass++;
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL reset_rsp_valid: got %b expected 0000", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0000) $display("FAIL reset_rsp_data: got %h expected 0000", rsp_data); else n_pass++;
    n_checks++; if (rsp_page !== 2'd0) $display("FAIL reset_rsp_page: got %0d expected 0", rsp_page); else n_pass++;
    n_checks++; if (mem_setaddr !== 1'b0) $display("FAIL reset_setaddr: got %b expected 0", mem_setaddr); else n_pass++;
    n_checks++; if (mem_paddr !== 6'd0) $display("FAIL reset_paddr: got %0d expected 0", mem_paddr); else n_pass++;
    n_checks++; if (fresh !== 4'b0000) $display("FAIL reset_fresh: got %b expected 0000", fresh); else n_pass++;
  endtask

  task automatic test_single_read();
    use_addr = 1'b0; fixed_word = 16'hA5A5;
    req_addr = 24'd5;
    req = 4'b0001;
    step(); // T: ISSUE
    n_checks++; if (gnt !== 4'b0001) $display("FAIL single_gnt: got %b expected 0001", gnt); else n_pass++;
    n_checks++; if (mem_setaddr !== 1'b1) $display("FAIL single_setaddr: got %b expected 1", mem_setaddr); else n_pass++;
    n_checks++; if (mem_paddr !== 6'd5) $display("FAIL single_paddr: got %0d expected 5", mem_paddr); else n_pass++;
    req_addr = 24'd9; // late address change must not matter
    mem_page = 2'd2;  // page changes mid-read
    step(); // T+1: WAIT
    n_checks++; if (gnt !== 4'b0000 || mem_setaddr !== 1'b0) $display("FAIL single_wait_strobe: got gnt=%b setaddr=%b expected 0000/0", gnt, mem_setaddr); else n_pass++;
    n_checks++; if (mem_paddr !== 6'd5) $display("FAIL single_paddr_hold: got %0d expected 5", mem_paddr); else n_pass++;
    step(); // T+2: WAIT
    n_checks++; if (rsp_valid !== 4'b0000) $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid); else n_pass++;
    step(); // T+3: RESP
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL single_rsp_valid: got %b expected 0001", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'hA5A5) $display("FAIL single_rsp_data: got %h expected a5a5", rsp_data); else n_pass++;
    n_checks++; if (rsp_page !== 2'd2) $display("FAIL single_rsp_page: got %0d expected 2", rsp_page); else n_pass++;
    req = 4'b0000;
    step();
    n_checks++; if (rsp_valid !== 4'b0000 || gnt !== 4'b0000) $display("FAIL single_idle: got rsp=%b gnt=%b expected 0000/0000", rsp_valid, gnt); else n_pass++;
    n_checks++; if (rsp_data !== 16'hA5A5) $display("FAIL single_data_hold: got %h expected a5a5", rsp_data); else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [3:0]  exp_g;
    logic [5:0]  exp_a;
    mem_page = 2'd1;
    do_reset();
    use_addr = 1'b1;
    req_addr = {6'd13, 6'd12, 6'd11, 6'd10};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = 4'b0001 << (n % 4);
      exp_a = 6'(10 + (n % 4));
      step(); // ISSUE
      n_checks++; if (gnt !== exp_g) $display("FAIL rr_gnt_%0d: got %b expected %b", n, gnt, exp_g); else n_pass++;
      n_checks++; if (mem_paddr !== exp_a) $display("FAIL rr_paddr_%0d: got %0d expected %0d", n, mem_paddr, exp_a); else n_pass++;
      step();
      step();
      n_checks++; if (gnt !== 4'b0000) $display("FAIL rr_gap_%0d: got %b expected 0000", n, gnt); else n_pass++;
      if (n == 4) req = 4'b0000;
      step(); // RESP
      if (n == 4) req = 4'b0000;
      n_checks++; if (rsp_valid !== exp_g || gnt !== 4'b0000) $display("FAIL rr_rsp_%0d: got rsp=%b gnt=%b expected %b/0000", n, rsp_valid, gnt, exp_g); else n_pass++;
      n_checks++; if (rsp_data !== 16'hB000 + {10'd0, exp_a}) $display("FAIL rr_data_%0d: got %h expected %h", n, rsp_data, 16'hB000 + {10'd0, exp_a}); else n_pass++;
    end
    step();
    n_checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) $display("FAIL rr_idle: got gnt=%b rsp=%b expected 0000/0000", gnt, rsp_valid); else n_pass++;
  endtask

  task automatic test_withdraw();
    do_reset();
    use_addr = 1'b1;
    req_addr = {6'd23, 6'd22, 6'd21, 6'd20};
    req = 4'b0111;
    step(); // ISSUE req0
    n_checks++; if (gnt !== 4'b0001) $display("FAIL wd_gnt0: got %b expected 0001", gnt); else n_pass++;
    step(); // WAIT
    req = 4'b0101; // req1 withdraws
    step(); // WAIT
    step(); // RESP req0
    n_checks++; if (rsp_valid !== 4'b0001) $display("FAIL wd_rsp0: got %b expected 0001", rsp_valid); else n_pass++;
    req = 4'b0100;
    step(); // ISSUE
    n_checks++; if (gnt !== 4'b0100) $display("FAIL wd_gnt2: got %b expected 0100", gnt); else n_pass++;
    n_checks++; if (mem_paddr !== 6'd22) $display("FAIL wd_paddr2: got %0d expected 22", mem_paddr); else n_pass++;
    step();
    step();
    step(); // RESP req2
    n_checks++; if (rsp_valid !== 4'b0100) $display("FAIL wd_rsp2: got %b expected 0100", rsp_valid); else n_pass++;
    n_checks++; if (rsp_data !== 16'hB016) $display("FAIL wd_data2: got %h expected b016", rsp_data); else n_pass++;
    req = 4'b0000;
    step();
    n_checks++; if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) $display("FAIL wd_no_req1: got gnt=%b rsp=%b expected 0000/0000", gnt, rsp_valid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int seen;
    req = 4'b0010;
    step(); // ISSUE req1
    n_checks++; if (gnt !== 4'b0010) $display("FAIL rm_gnt: got %b expected 0010", gnt); else n_pass++;
    step(); // WAIT
    resetq = 1'b0;
    step(); // reset took effect
    req = 4'b0000;
    n_checks++; if (gnt !== 4'b0000 || mem_setaddr !== 1'b0) $display("FAIL rm_strobe: got gnt=%b setaddr=%b expected 0000/0", gnt, mem_setaddr); else n_pass++;
    n_checks++; if (mem_paddr !== 6'd0) $display("FAIL rm_paddr: got %0d expected 0", mem_paddr); else n_pass++;
    n_checks++; if (rsp_data !== 16'h0000 || rsp_page !== 2'd0) $display("FAIL rm_rsp_regs: got data=%h page=%0d expected 0000/0", rsp_data, rsp_page); else n_pass++;
    resetq = 1'b1;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (rsp_valid !== 4'b0000) seen++;
      step();
    end
    n_checks++; if (seen !== 0) $display("FAIL rm_no_rsp: got %0d responses expected 0", seen); else n_pass++;
  endtask

`ifdef SPIPKT_ARB_FRESH_EN
  task automatic test_fresh();
    mem_page = 2'd1;
    do_reset();
    n_checks++; if (fresh !== 4'b0000) $display("FAIL fr_release: got %b expected 0000", fresh); else n_pass++;
    mem_page = 2'd2;
    step();
    n_checks++; if (fresh !== 4'b1111) $display("FAIL fr_set: got %b expected 1111", fresh); else n_pass++;
    fresh_clr = 4'b0100;
    step();
    fresh_clr = 4'b0000;
    n_checks++; if (fresh !== 4'b1011) $display("FAIL fr_clr: got %b expected 1011", fresh); else n_pass++;
    mem_page = 2'd3;
    fresh_clr = 4'b0001;
    step();
    fresh_clr = 4'b0000;
    n_checks++; if (fresh !== 4'b1111) $display("FAIL fr_set_wins: got %b expected 1111", fresh); else n_pass++;
    fresh_clr = 4'b1111;
    step();
    fresh_clr = 4'b0000;
    n_checks++; if (fresh !== 4'b0000) $display("FAIL fr_clr_all: got %b expected 0000", fresh); else n_pass++;
  endtask
`else
  task automatic test_fresh();
    mem_page = 2'd1;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      mem_page = 2'(i);
      fresh_clr = 4'(i);
      step();
      n_checks++; if (fresh !== 4'b0000) $display("FAIL fr_off_%0d: got %b expected 0000", i, fresh); else n_pass++;
    end
    fresh_clr = 4'b0000;
  endtask
`endif

  initial begin
    clk = 1'b0; resetq = 1'b0; req = 4'b0000; req_addr = 24'd0;
    mem_page = 2'd1; fresh_clr = 4'b0000; use_addr = 1'b0; fixed_word = 16'h0000;
    n_checks = 0; n_pass = 0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_withdraw();
    test_reset_mid();
    test_fresh();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
